// File: rtl/dso_pkg.sv
// Shared constants and the capture FSM state type for the DSO sample-buffer controller.
package dso_pkg;

    localparam int DEPTH  = 512;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int DEC_W  = 4;
    // Fill, post-trigger and readout counters must be able to hold DEPTH itself.
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_TRIG,
        POST,
        DONE,
        DUMP
    } state_t;

endpackage

// File: rtl/dso_decimator.sv
// Sample decimator: passes one of every 2^decim ADC strobes, counting from the last clear.
module dso_decimator
    import dso_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             smpl_vld,
    input  logic [DEC_W-1:0] decim,
    output logic             keep
);

    // Wide enough for the largest ratio; 2^decim always divides the wrap point.
    localparam int CW = (1 << DEC_W) - 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] mask;

    always_comb begin
        mask = (CW'(1) << decim) - CW'(1);
        keep = smpl_vld && !clear && ((cnt & mask) == '0);
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (smpl_vld) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dso_capture_ctrl.sv
// Circular pre/post-trigger capture sequencer for the 512x8 DSO sample RAM, with
// chronological readout over a valid/ready stream. RAM runs on a clk/2 slot clock.
module dso_capture_ctrl
    import dso_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              trig,
    input  logic              smpl_vld,
    input  logic [DATA_W-1:0] smpl_data,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  decim,
    input  logic              dump_req,
    input  logic              dump_rdy,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_vld,
    output logic              armed,
    output logic              capture_done,
    output logic              rclk,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t state, state_n;

    logic [ADDR_W-1:0] wr_ptr, start_ptr, rd_ptr;
    logic [CNT_W-1:0]  fill_cnt, post_cnt, rd_iss, rd_cnt;
    logic              hold_vld;
    logic [DATA_W-1:0] hold_data;
    logic              rd_pend;

    logic keep, slot, writing, do_arm, wr_fire, rd_fire, xfer;
    logic pre_hit, post_hit, last_xfer, enter_dump;

    dso_decimator u_decim (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (do_arm),
        .smpl_vld (smpl_vld),
        .decim    (decim),
        .keep     (keep)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        slot       = rclk;  // this edge takes rclk 1->0: the only edge the RAM port may change
        writing    = (state == ARMED) || (state == WAIT_TRIG) || (state == POST);
        armed      = writing;
        do_arm     = arm && (state != DUMP);
        wr_fire    = slot && writing && hold_vld && !do_arm;
        rd_fire    = slot && (state == DUMP) && !rd_pend && (rd_iss != CNT_W'(DEPTH))
                     && (!dump_vld || dump_rdy);
        xfer       = dump_vld && dump_rdy;
        pre_hit    = (fill_cnt + CNT_W'(1)) == (CNT_W'(DEPTH) - {1'b0, trig_pos});
        post_hit   = (post_cnt + CNT_W'(1)) == {1'b0, trig_pos};
        last_xfer  = xfer && (rd_cnt == CNT_W'(DEPTH - 1));
        enter_dump = (state == DONE) && dump_req && !arm;

        state_n = state;
        case (state)
            IDLE:      if (do_arm) state_n = ARMED;
            ARMED:     if (do_arm) state_n = ARMED;
                       else if (wr_fire && pre_hit) state_n = WAIT_TRIG;
            WAIT_TRIG: if (do_arm) state_n = ARMED;
                       else if (trig) state_n = POST;
            POST:      if (do_arm) state_n = ARMED;
                       else if (wr_fire && post_hit) state_n = DONE;
            DONE:      if (do_arm) state_n = ARMED;
                       else if (dump_req) state_n = DUMP;
            DUMP:      if (last_xfer) state_n = DONE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Capture side: holding register, write pointer and fill/post counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rclk         <= 1'b0;
            wr_ptr       <= '0;
            start_ptr    <= '0;
            fill_cnt     <= '0;
            post_cnt     <= '0;
            hold_vld     <= 1'b0;
            hold_data    <= '0;
            capture_done <= 1'b0;
        end else begin
            rclk <= ~rclk;
            if (do_arm) begin
                wr_ptr       <= '0;
                fill_cnt     <= '0;
                hold_vld     <= 1'b0;
                capture_done <= 1'b0;
            end else begin
                if (wr_fire) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wr_fire && (state == ARMED)) fill_cnt <= fill_cnt + CNT_W'(1);
                // A fresh sample wins over draining, so an overrun overwrites the holder.
                if (keep && writing) begin
                    hold_vld  <= 1'b1;
                    hold_data <= smpl_data;
                end else if (wr_fire) begin
                    hold_vld <= 1'b0;
                end
                if ((state == POST) && wr_fire && post_hit) begin
                    start_ptr    <= wr_ptr + ADDR_W'(1);
                    capture_done <= 1'b1;
                end
            end
            if ((state == WAIT_TRIG) && trig && !do_arm) begin
                post_cnt <= '0;
            end else if (wr_fire && (state == POST)) begin
                post_cnt <= post_cnt + CNT_W'(1);
            end
        end
    end

    // Readout side and the registered RAM port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            rd_iss    <= '0;
            rd_cnt    <= '0;
            rd_pend   <= 1'b0;
            dump_data <= '0;
            dump_vld  <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if (enter_dump) begin
                rd_ptr <= start_ptr;
                rd_iss <= '0;
                rd_cnt <= '0;
            end else begin
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                    rd_iss <= rd_iss + CNT_W'(1);
                end
                if (xfer) rd_cnt <= rd_cnt + CNT_W'(1);
            end

            // Data of a read issued one slot ago is valid at this slot edge.
            if (slot) rd_pend <= rd_fire;
            if (slot && rd_pend) begin
                dump_data <= ram_rdata;
                dump_vld  <= 1'b1;
            end else if (xfer) begin
                dump_vld <= 1'b0;
            end

            if (slot) begin
                if (wr_fire) begin
                    ram_en    <= 1'b1;
                    ram_we    <= 1'b1;
                    ram_addr  <= wr_ptr;
                    ram_wdata <= hold_data;
                end else if (rd_fire) begin
                    ram_en   <= 1'b1;
                    ram_we   <= 1'b0;
                    ram_addr <= rd_ptr;
                end else begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dso_capture_ctrl.sv
// Self-checking bench for dso_capture_ctrl: behavioural RAM on rclk, a kept-sample
// history model, and a scoreboard queue of expected readout bytes.
module tb_dso_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0, trig = 1'b0, smpl_vld = 1'b0, dump_req = 1'b0, dump_rdy = 1'b1;
    logic [7:0] smpl_data = '0;
    logic [8:0] trig_pos = 9'd100;
    logic [3:0] decim = '0;
    logic [7:0] dump_data, ram_wdata, ram_rdata;
    logic       dump_vld, armed, capture_done, rclk, ram_en, ram_we;
    logic [8:0] ram_addr;

    int n_cmp = 0, n_bad = 0;
    int strobes = 0;
    logic [7:0] hist[$];
    logic [7:0] exp_q[$];
    logic [7:0] mem [0:511];
    int wr_count = 0, rd_seen = 0, xfers = 0;
    int rd_base = 0, rd_seen0 = 0;
    logic stall_prev = 1'b0;
    logic [7:0] stall_data = '0;

    dso_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .trig(trig), .smpl_vld(smpl_vld),
        .smpl_data(smpl_data), .trig_pos(trig_pos), .decim(decim), .dump_req(dump_req),
        .dump_rdy(dump_rdy), .dump_data(dump_data), .dump_vld(dump_vld), .armed(armed),
        .capture_done(capture_done), .rclk(rclk), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Synchronous RAM clocked by the DUT's slot clock.
    always @(posedge rclk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr_count <= wr_count + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    // Readout addresses must walk from the oldest sample and wrap 511 -> 0.
    always @(posedge rclk) begin
        if (ram_en && !ram_we) begin
            check("rd_addr", 32'(ram_addr), 32'((rd_base + rd_seen - rd_seen0) % 512));
            rd_seen <= rd_seen + 1;
        end
    end

    // Scoreboard pop on every completed transfer; stalled words must hold.
    always @(negedge clk) begin
        if (stall_prev) begin
            check("stall_vld", 32'(dump_vld), 32'd1);
            check("stall_data", 32'(dump_data), 32'(stall_data));
        end
        stall_prev = dump_vld && !dump_rdy;
        stall_data = dump_data;
        if (dump_vld && dump_rdy) begin
            xfers++;
            check("dump_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("dump_data", 32'(dump_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        strobes = 0;
        hist.delete();
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Ramp samples every 2 clk; the model records which ones the decimator keeps.
    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            smpl_vld  = 1'b1;
            smpl_data = 8'(first + i);
            if ((strobes & ((1 << decim) - 1)) == 0) hist.push_back(8'(first + i));
            strobes++;
            tick();
            smpl_vld = 1'b0;
            tick();
        end
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 400 && !capture_done; c++) tick();
        check(tag, 32'(capture_done), 32'd1);
    endtask

    // Expected readout is the last DEPTH kept samples, oldest first.
    task automatic run_dump(input string tag, input bit stall);
        int n, x0;
        n = hist.size();
        for (int i = n - 512; i < n; i++) exp_q.push_back(hist[i]);
        rd_base  = n % 512;
        rd_seen0 = rd_seen;
        x0       = xfers;
        dump_rdy = 1'b1;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int c = 0; c < 20000 && exp_q.size() > 0; c++) begin
            dump_rdy = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            tick();
        end
        dump_rdy = 1'b1;
        tick(8);
        check({tag, "_xfers"}, 32'(xfers - x0), 32'd512);
        check({tag, "_reads"}, 32'(rd_seen - rd_seen0), 32'd512);
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_done_kept"}, 32'(capture_done), 32'd1);
        check({tag, "_vld_idle"}, 32'(dump_vld), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_armed"}, 32'(armed), 32'd0);
        check({tag, "_done"}, 32'(capture_done), 32'd0);
        check({tag, "_rclk"}, 32'(rclk), 32'd0);
        check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
        check({tag, "_dump_vld"}, 32'(dump_vld), 32'd0);
        check({tag, "_dump_data"}, 32'(dump_data), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        #2;
        check_reset_outputs("por");
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Ramp capture, trigger after sample 600, 100 post samples.
        decim    = 4'd0;
        trig_pos = 9'd100;
        pulse_arm();
        check("t2_armed", 32'(armed), 32'd1);
        feed(0, 601);
        tick(6);
        pulse_trig();
        feed(601, 100);
        wait_done("t2_done");
        check("t2_armed_off", 32'(armed), 32'd0);
        run_dump("t2_dump", 1'b0);

        // Trigger pulses in ARMED are ignored; the one at sample 450 counts.
        pulse_arm();
        check("t3_done_clr", 32'(capture_done), 32'd0);
        feed(0, 100);
        pulse_trig();
        feed(100, 200);
        pulse_trig();
        feed(300, 105);
        pulse_trig();
        feed(405, 45);
        tick(6);
        pulse_trig();
        feed(450, 100);
        wait_done("t3_done");
        run_dump("t5_stall_dump", 1'b1);

        // Decimation by 4: 412 writes of every 4th value, then 100 post writes.
        decim = 4'd2;
        pulse_arm();
        w0 = wr_count;
        feed(0, 1648);
        tick(8);
        check("t4_pre_writes", 32'(wr_count - w0), 32'd412);
        check("t4_still_armed", 32'(armed), 32'd1);
        check("t4_not_done", 32'(capture_done), 32'd0);
        pulse_trig();
        feed(1648, 400);
        wait_done("t4_done");
        check("t4_all_writes", 32'(wr_count - w0), 32'd512);
        run_dump("t4_dump", 1'b0);

        // Re-arm in WAIT_TRIG restarts the fill; dump_req while armed does nothing.
        decim = 4'd0;
        pulse_arm();
        feed(0, 20);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        tick(10);
        check("t6_dumpreq_ignored", 32'(dump_vld), 32'd0);
        feed(20, 430);
        tick(6);
        pulse_arm();
        check("t6_rearm_done", 32'(capture_done), 32'd0);
        check("t6_rearm_armed", 32'(armed), 32'd1);
        feed(1000, 411);
        tick(6);
        pulse_trig();
        feed(1411, 1);
        tick(6);
        pulse_trig();
        feed(1412, 100);
        wait_done("t6_done");
        run_dump("t6_dump", 1'b0);

        // Asynchronous reset in the middle of POST.
        pulse_arm();
        feed(0, 420);
        tick(6);
        pulse_trig();
        feed(420, 20);
        check("t1_in_post", 32'(armed), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t1_async");
        tick(3);
        check("t1_rclk_held", 32'(rclk), 32'd0);
        rst_n = 1'b1;
        tick();
        check("t1_rclk_restart", 32'(rclk), 32'd1);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        feed(0, 4);
        check("t1_idle_vld", 32'(dump_vld), 32'd0);
        check("t1_idle_ram_en", 32'(ram_en), 32'd0);
        check("t1_idle_armed", 32'(armed), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
